gfx_vram_fetch: RTL

//  Sequences VRAM reads that feed the colour-plane pixel datapath. Per 8-pixel cell, fetches six

---
 rtl/gfx_pkg.sv | 26 ++
 rtl/gfx_vram_fetch_if.sv | 38 +++
 rtl/gfx_cell_addr.sv | 32 +++
 rtl/gfx_vram_fetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the VRAM fetch sequencer: display geometry, plane
// indices as presented on vram_plane, and the fetch/CPU FSM state encoding.
package gfx_pkg;

   localparam int          LINE_BYTES = 24;       // cells per active line
   localparam int          V_ACTIVE   = 184;      // active display lines
   localparam int          V_TOTAL    = 262;      // total lines per frame
   localparam int          H_GROUPS   = 32;       // 8-pixel groups per total line
   localparam logic [12:0] BASE_ADDR  = 13'hEC0;  // line 0, cell 0

   localparam logic [2:0] PL_FG1 = 3'd0;
   localparam logic [2:0] PL_FG2 = 3'd1;
   localparam logic [2:0] PL_FG3 = 3'd2;
   localparam logic [2:0] PL_BG1 = 3'd3;
   localparam logic [2:0] PL_BG2 = 3'd4;
   localparam logic [2:0] PL_BG3 = 3'd5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_F0, ST_F1, ST_F2, ST_F3, ST_F4, ST_F5,
      ST_FL,
      ST_CA,
      ST_CD
   } fetch_state_t;

endpackage

// File: rtl/gfx_vram_fetch_if.sv
// Shared VRAM port plus the CPU request port that is multiplexed onto it.
//  master : the fetch sequencer (drives VRAM strobes/address, answers CPU)
//  slave  : the environment (VRAM bank mux returning vram_q, CPU requester)
//  vram_rd/vram_we/vram_plane/vram_addr/vram_wdata : VRAM access, vram_q 1-clk later
//  cpu_req/cpu_we/cpu_plane/cpu_addr/cpu_wdata     : CPU request, held until cpu_ack
//  cpu_rdata/cpu_ack                               : CPU completion
interface gfx_vram_fetch_if;

   logic        vram_rd;
   logic        vram_we;
   logic [2:0]  vram_plane;
   logic [12:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_q;

   logic        cpu_req;
   logic        cpu_we;
   logic [2:0]  cpu_plane;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;

   modport master (
      output vram_rd, vram_we, vram_plane, vram_addr, vram_wdata,
      input  vram_q,
      input  cpu_req, cpu_we, cpu_plane, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack
   );

   modport slave (
      input  vram_rd, vram_we, vram_plane, vram_addr, vram_wdata,
      output vram_q,
      output cpu_req, cpu_we, cpu_plane, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack
   );

endinterface

// File: rtl/gfx_cell_addr.sv
// Next-cell calculator: from the current 8-pixel group and line, works out
// which cell is fetched ahead, whether it lies in the active window, and its
// plane-relative VRAM address.
//  grp    in  6   current group, h[8:3]
//  v      in  9   current line
//  addr   out 13  BASE_ADDR + line*LINE_BYTES + col, mod 2^13
//  active out 1   cell inside the active window
module gfx_cell_addr
   import gfx_pkg::*;
(
   input  logic [5:0]  grp,
   input  logic [8:0]  v,
   output logic [12:0] addr,
   output logic        active
);

   logic [6:0] col;
   logic [8:0] line;

   always_comb begin
      col  = {1'b0, grp} + 7'd1;
      line = v;
      // The last group of a line prefetches cell 0 of the following line.
      if (grp == 6'(H_GROUPS - 1)) begin
         col  = '0;
         line = (v == 9'(V_TOTAL - 1)) ? 9'd0 : v + 9'd1;
      end
      active = (col < 7'(LINE_BYTES)) && (line < 9'(V_ACTIVE));
      addr   = BASE_ADDR + 13'(line) * 13'(LINE_BYTES) + 13'(col);
   end

endmodule

// File: rtl/gfx_vram_fetch.sv
// VRAM fetch sequencer for the colour-plane pixel path. On each cell boundary
// it loads the six prefetched plane bytes to the outputs and starts fetching
// the next cell into shadow registers; idle slots serve CPU accesses.
//  clk, reset_n   clock, synchronous active-low reset
//  ce_pix, h, v   pixel strobe and counters; trigger = ce_pix & h[2:0]==0
//  bus            VRAM port and CPU port (master side)
//  fg1..bg3       plane bytes for the current cell
//  overrun        sticky: a trigger arrived while a fetch was in progress
module gfx_vram_fetch
   import gfx_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ce_pix,
   input  logic [8:0]              h,
   input  logic [8:0]              v,
   gfx_vram_fetch_if.master        bus,
   output logic [7:0]              fg1,
   output logic [7:0]              fg2,
   output logic [7:0]              fg3,
   output logic [7:0]              bg1,
   output logic [7:0]              bg2,
   output logic [7:0]              bg3,
   output logic                    overrun
);

   fetch_state_t     state_q, state_d;
   logic             rd_q, rd_d, we_q, we_d, ack_q, ack_d;
   logic             pend_q, pend_d, overrun_q, overrun_d;
   logic [2:0]       plane_q, plane_d;
   logic [12:0]      addr_q, addr_d, fetch_addr_q, fetch_addr_d;
   logic [7:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic [5:0][7:0]  shadow_q, shadow_d, out_q, out_d;

   logic             trig, busy, cell_active;
   logic [12:0]      cell_addr;

   gfx_cell_addr u_cell_addr (
      .grp    (h[8:3]),
      .v      (v),
      .addr   (cell_addr),
      .active (cell_active)
   );

   assign trig = ce_pix && (h[2:0] == 3'd0);
   assign busy = (state_q >= ST_F0) && (state_q <= ST_FL);

   always_comb begin
      state_d      = state_q;
      rd_d         = rd_q;
      we_d         = we_q;
      plane_d      = plane_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      ack_d        = 1'b0;
      pend_d       = pend_q;
      overrun_d    = overrun_q;
      fetch_addr_d = fetch_addr_q;
      shadow_d     = shadow_q;
      out_d        = out_q;

      // vram_q lags vram_rd by one clk, so plane p lands while in state F(p+1).
      case (state_q)
         ST_IDLE: begin
            // ack_q masks the still-held request in the clk the ack is seen.
            if (bus.cpu_req && !ack_q && !trig) begin
               state_d = ST_CA;
               rd_d    = !bus.cpu_we;
               we_d    = bus.cpu_we;
               plane_d = bus.cpu_plane;
               addr_d  = bus.cpu_addr;
               wdata_d = bus.cpu_wdata;
            end
         end
         ST_F0: begin state_d = ST_F1; plane_d = PL_FG2; end
         ST_F1: begin shadow_d[0] = bus.vram_q; state_d = ST_F2; plane_d = PL_FG3; end
         ST_F2: begin shadow_d[1] = bus.vram_q; state_d = ST_F3; plane_d = PL_BG1; end
         ST_F3: begin shadow_d[2] = bus.vram_q; state_d = ST_F4; plane_d = PL_BG2; end
         ST_F4: begin shadow_d[3] = bus.vram_q; state_d = ST_F5; plane_d = PL_BG3; end
         ST_F5: begin shadow_d[4] = bus.vram_q; state_d = ST_FL; rd_d = 1'b0;     end
         ST_FL: begin shadow_d[5] = bus.vram_q; state_d = ST_IDLE;                end
         ST_CA: begin
            state_d = ST_CD;
            rd_d    = 1'b0;
            we_d    = 1'b0;
         end
         ST_CD: begin
            ack_d   = 1'b1;
            if (!bus.cpu_we) rdata_d = bus.vram_q;
            state_d = ST_IDLE;
            // A cell boundary seen during the CPU slot starts its fetch now.
            if (pend_q) begin
               state_d = ST_F0;
               rd_d    = 1'b1;
               plane_d = PL_FG1;
               addr_d  = fetch_addr_q;
               pend_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Cell boundary: load outputs from the shadows and (re)start the fetch.
      // This overrides whatever the sequencing above chose, except that a CPU
      // access already on the bus (CA) is allowed to finish.
      if (trig) begin
         out_d = shadow_q;
         if (busy) overrun_d = 1'b1;
         if (!cell_active) begin
            shadow_d = '0;
            pend_d   = 1'b0;
            if (state_q != ST_CA) begin
               state_d = ST_IDLE;
               rd_d    = 1'b0;
               we_d    = 1'b0;
            end
         end else if (state_q == ST_CA) begin
            pend_d       = 1'b1;
            fetch_addr_d = cell_addr;
         end else begin
            state_d = ST_F0;
            rd_d    = 1'b1;
            we_d    = 1'b0;
            plane_d = PL_FG1;
            addr_d  = cell_addr;
            pend_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         rd_q         <= 1'b0;
         we_q         <= 1'b0;
         plane_q      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         ack_q        <= 1'b0;
         pend_q       <= 1'b0;
         overrun_q    <= 1'b0;
         fetch_addr_q <= '0;
         shadow_q     <= '0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         rd_q         <= rd_d;
         we_q         <= we_d;
         plane_q      <= plane_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         ack_q        <= ack_d;
         pend_q       <= pend_d;
         overrun_q    <= overrun_d;
         fetch_addr_q <= fetch_addr_d;
         shadow_q     <= shadow_d;
         out_q        <= out_d;
      end
   end

   assign bus.vram_rd    = rd_q;
   assign bus.vram_we    = we_q;
   assign bus.vram_plane = plane_q;
   assign bus.vram_addr  = addr_q;
   assign bus.vram_wdata = wdata_q;
   assign bus.cpu_rdata  = rdata_q;
   assign bus.cpu_ack    = ack_q;

   assign fg1     = out_q[0];
   assign fg2     = out_q[1];
   assign fg3     = out_q[2];
   assign bg1     = out_q[3];
   assign bg2     = out_q[4];
   assign bg3     = out_q[5];
   assign overrun = overrun_q;

endmodule
